z80_bus_master: RTL and testbench
=================================

Z80_BUS_MASTER -- requirements
Module: z80_bus_master

Interface
REQ-001 SHALL have parameter T_DIV, default 4, meaning clk cycles per Z80 T-state (legal range 2..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, meaning idle clk cycles bus ownership is kept after a cycle before release.
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, width 1: command request.
REQ-006 SHALL have port cmd_ready, output, width 1: command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have ports cmd_write (input, 1), cmd_io (input, 1), cmd_addr (input, 16) and cmd_wdata (input, 8): the write flag, the I/O-versus-memory flag, the address, and the write data.
REQ-008 SHALL have port rsp_valid, output, width 1: one-clk pulse at cycle completion.
REQ-009 SHALL have port rsp_rdata, output, width 8: read data, valid with rsp_valid.
REQ-010 SHALL have ports z80_busreq (output, 1) and z80_busack (input, 1), both active-low.
REQ-011 SHALL have port z80_wait, input, width 1: active-low wait request.
REQ-012 SHALL have ports z80_a (output, 16), z80_d_out (output, 8), z80_d_in (input, 8) and z80_d_oe (output, 1).
REQ-013 SHALL have ports z80_mreq, z80_iorq, z80_rd and z80_wr, each output, width 1, active-low.
REQ-014 SHALL have port z80_ctrl_oe, output, width 1: drive enable for z80_a and the four strobes.

Function
REQ-015 SHALL pass z80_busack and z80_wait each through a 2-flop synchronizer before use.
REQ-016 SHALL implement states IDLE, REQ, OWN, T1, T2, TW, T3 and REL.
REQ-017 IDLE: cmd_ready=1; on accept, latch the command and go to REQ, asserting z80_busreq=0.
REQ-018 REQ: cmd_ready=0; on synchronized busack=0, assert z80_ctrl_oe=1 with all strobes high and go to T1.
REQ-019 T1 (T_DIV clks): drive z80_a=addr; for writes, z80_d_oe=1 and z80_d_out=wdata.
REQ-020 T2 (T_DIV clks): memory cycles assert mreq together with rd or wr; I/O cycles assert iorq together with rd or wr.
REQ-021 On the last clk of T2, SHALL go to TW; an I/O cycle SHALL always insert exactly one mandatory TW, and further TWs SHALL follow the wait rule.
REQ-022 On the last clk of each TW, SHALL go to another TW if synchronized wait=0, else to T3.
REQ-023 A memory cycle with synchronized wait=1 at the last clk of T2 SHALL go directly to T3 with no TW.
REQ-024 T3 (T_DIV clks): strobes stay asserted; on the last clk of T3, sample z80_d_in into rsp_rdata for reads.
REQ-025 At the end of T3, SHALL deassert all strobes and set z80_d_oe=0.
REQ-026 SHALL pulse rsp_valid on the clk following the end of T3; rsp_rdata SHALL hold its value until the next read.
REQ-027 OWN: cmd_ready=1, bus still driven with strobes high; an accepted command SHALL go straight to T1 with no new busreq.
REQ-028 OWN: after HOLD_CYCLES clks with no accept, SHALL go to REL.
REQ-029 REL (1 clk): z80_ctrl_oe=0, z80_busreq=1, then IDLE; cmd_ready=0 in REL.
REQ-030 Simultaneous cmd_valid and hold-counter expiry in OWN: the accept SHALL win.
REQ-031 SHALL ignore a busack deassertion while owning the bus; the current cycle completes.
REQ-032 SHALL assert at most one of rd/wr and at most one of mreq/iorq at any time.

Reset
REQ-033 While rst_n=0, outputs SHALL be: z80_busreq=1, z80_mreq=1, z80_iorq=1, z80_rd=1, z80_wr=1, z80_ctrl_oe=0, z80_d_oe=0, z80_a=0, z80_d_out=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0.
REQ-034 Reset SHALL take effect asynchronously, including mid-cycle, where it aborts the cycle with no rsp_valid; the state SHALL be IDLE and synchronizers SHALL be set to 1.
REQ-035 cmd_ready SHALL rise on the first clk after rst_n deasserts.

Verification
REQ-036 Memory read 0x1234 with busack responding after 3 clks and wait=1 -> busreq low, then T1..T3 of 4 clks each with mreq/rd low for 8 clks, rsp_valid pulses with rsp_rdata equal to the z80_d_in sampled value 0xA5.
REQ-037 I/O write 0x3039 with data 0x5A -> iorq/wr low for exactly 12 clks (T2+TW+T3), z80_d_oe high from T1 through T3, rsp_valid pulses once.
REQ-038 Memory read with wait held low for 10 clks -> TW repeats until synchronized wait=1, with strobes extended accordingly.
REQ-039 Back-to-back commands issued 2 clks after rsp_valid -> no busreq toggle, second cycle starts from OWN; after HOLD_CYCLES=8 idle clks, REL then busreq=1.
REQ-040 rst_n low during T2 -> strobes high and ctrl_oe=0 immediately, no rsp_valid, IDLE after release.

Source files
------------

// File: rtl/z80_bus_master.sv
// Z80 bus master: requests the bus via BUSREQ/BUSACK, runs single memory or I/O
// read/write cycles with T-state timing and WAIT handling, then releases after an idle hold.
module z80_bus_master #(
    parameter int T_DIV       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_io,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        z80_busreq,
    input  logic        z80_busack,
    input  logic        z80_wait,
    output logic [15:0] z80_a,
    output logic [7:0]  z80_d_out,
    input  logic [7:0]  z80_d_in,
    output logic        z80_d_oe,
    output logic        z80_mreq,
    output logic        z80_iorq,
    output logic        z80_rd,
    output logic        z80_wr,
    output logic        z80_ctrl_oe
);

    localparam int TCW = $clog2(T_DIV + 1);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(T_DIV - 1);
    localparam logic [HCW-1:0] H_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        OWN,
        T1,
        T2,
        TW,
        T3,
        REL
    } state_t;

    state_t         state;
    logic [TCW-1:0] tcnt;
    logic [HCW-1:0] hold;

    logic           busack_m, busack_s;
    logic           wait_m, wait_s;

    logic           q_write;
    logic           q_io;
    logic [15:0]    q_addr;
    logic [7:0]     q_wdata;

    logic           accept;
    assign accept = cmd_valid && cmd_ready;

    // Both Z80-side inputs are asynchronous to clk; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busack_m <= 1'b1;
            busack_s <= 1'b1;
            wait_m   <= 1'b1;
            wait_s   <= 1'b1;
        end else begin
            busack_m <= z80_busack;
            busack_s <= busack_m;
            wait_m   <= z80_wait;
            wait_s   <= wait_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tcnt        <= '0;
            hold        <= '0;
            q_write     <= 1'b0;
            q_io        <= 1'b0;
            q_addr      <= '0;
            q_wdata     <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            z80_busreq  <= 1'b1;
            z80_a       <= '0;
            z80_d_out   <= '0;
            z80_d_oe    <= 1'b0;
            z80_mreq    <= 1'b1;
            z80_iorq    <= 1'b1;
            z80_rd      <= 1'b1;
            z80_wr      <= 1'b1;
            z80_ctrl_oe <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_write    <= cmd_write;
                        q_io       <= cmd_io;
                        q_addr     <= cmd_addr;
                        q_wdata    <= cmd_wdata;
                        cmd_ready  <= 1'b0;
                        z80_busreq <= 1'b0;
                        state      <= REQ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                REQ: begin
                    if (!busack_s) begin
                        z80_ctrl_oe <= 1'b1;
                        z80_a       <= q_addr;
                        z80_d_oe    <= q_write;
                        if (q_write) begin
                            z80_d_out <= q_wdata;
                        end
                        tcnt  <= T_LAST;
                        state <= T1;
                    end
                end

                OWN: begin
                    // An accept takes priority over hold expiry on the same clk.
                    if (accept) begin
                        q_write   <= cmd_write;
                        q_io      <= cmd_io;
                        q_addr    <= cmd_addr;
                        q_wdata   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        z80_a     <= cmd_addr;
                        z80_d_oe  <= cmd_write;
                        if (cmd_write) begin
                            z80_d_out <= cmd_wdata;
                        end
                        tcnt  <= T_LAST;
                        state <= T1;
                    end else if (hold == '0) begin
                        cmd_ready   <= 1'b0;
                        z80_ctrl_oe <= 1'b0;
                        z80_busreq  <= 1'b1;
                        state       <= REL;
                    end else begin
                        hold <= hold - HCW'(1);
                    end
                end

                T1: begin
                    if (tcnt == '0) begin
                        z80_mreq <= q_io;
                        z80_iorq <= !q_io;
                        z80_rd   <= q_write;
                        z80_wr   <= !q_write;
                        tcnt     <= T_LAST;
                        state    <= T2;
                    end else begin
                        tcnt <= tcnt - TCW'(1);
                    end
                end

                T2: begin
                    if (tcnt == '0) begin
                        tcnt  <= T_LAST;
                        state <= (q_io || !wait_s) ? TW : T3;
                    end else begin
                        tcnt <= tcnt - TCW'(1);
                    end
                end

                TW: begin
                    if (tcnt == '0) begin
                        tcnt  <= T_LAST;
                        state <= (!wait_s) ? TW : T3;
                    end else begin
                        tcnt <= tcnt - TCW'(1);
                    end
                end

                T3: begin
                    if (tcnt == '0) begin
                        z80_mreq  <= 1'b1;
                        z80_iorq  <= 1'b1;
                        z80_rd    <= 1'b1;
                        z80_wr    <= 1'b1;
                        z80_d_oe  <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (!q_write) begin
                            rsp_rdata <= z80_d_in;
                        end
                        cmd_ready <= 1'b1;
                        hold      <= H_LAST;
                        state     <= OWN;
                    end else begin
                        tcnt <= tcnt - TCW'(1);
                    end
                end

                REL: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// Bench for z80_bus_master: a responsive Z80 bus model drives BUSACK/WAIT/data and
// records what the master does; scenario tasks compare against cycle-level expectations.
module tb_z80_bus_master;

    localparam int T_DIV = 4;
    localparam int HOLD  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_io = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        z80_busreq;
    logic        z80_busack = 1'b1;
    logic        z80_wait = 1'b1;
    logic [15:0] z80_a;
    logic [7:0]  z80_d_out;
    logic [7:0]  z80_d_in = '0;
    logic        z80_d_oe;
    logic        z80_mreq;
    logic        z80_iorq;
    logic        z80_rd;
    logic        z80_wr;
    logic        z80_ctrl_oe;

    z80_bus_master #(.T_DIV(T_DIV), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_io(cmd_io), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .z80_busreq(z80_busreq), .z80_busack(z80_busack), .z80_wait(z80_wait),
        .z80_a(z80_a), .z80_d_out(z80_d_out), .z80_d_in(z80_d_in), .z80_d_oe(z80_d_oe),
        .z80_mreq(z80_mreq), .z80_iorq(z80_iorq), .z80_rd(z80_rd), .z80_wr(z80_wr),
        .z80_ctrl_oe(z80_ctrl_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Bus model state and observations
    int          cyc = 0;
    int          wait_len = 0;
    int          ack_dly = 3;
    logic        drop_ack = 1'b0;
    int          ack_cnt = 0;
    int          run = 0;
    int          e0 = 0;
    int          last_len = 0;
    int          viol = 0;
    int          doe_cnt = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    int          rise_cyc = 0;
    logic        ready_at_rise = 1'b0;
    int          busreq_falls = 0;
    logic        prev_busreq = 1'b1;
    logic        obs_io, obs_wr, obs_rd, addr_stable, doe_all, doe_any, active;
    logic [15:0] obs_addr;
    logic [7:0]  obs_dout;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        active = !z80_mreq || !z80_iorq;
        if ((!z80_rd && !z80_wr) || (!z80_mreq && !z80_iorq)) viol++;
        if (z80_d_oe) doe_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
        end
        if (prev_busreq && !z80_busreq) busreq_falls++;
        if (!prev_busreq && z80_busreq) begin
            rise_cyc      = cyc;
            ready_at_rise = cmd_ready;
        end
        prev_busreq = z80_busreq;
        if (active) begin
            if (run == 0) begin
                e0          = cyc;
                obs_io      = !z80_iorq;
                obs_wr      = !z80_wr;
                obs_rd      = !z80_rd;
                obs_addr    = z80_a;
                obs_dout    = z80_d_out;
                addr_stable = 1'b1;
                doe_all     = 1'b1;
                doe_any     = 1'b0;
            end
            if (z80_a !== obs_addr) addr_stable = 1'b0;
            doe_all = doe_all & z80_d_oe;
            doe_any = doe_any | z80_d_oe;
            run++;
        end else if (run > 0) begin
            last_len = run;
            run = 0;
        end
        // WAIT is held low for wait_len clks counted from the first strobe edge.
        z80_wait = !(active && (cyc + 1 - e0) < wait_len);
        if (!z80_busreq) begin
            ack_cnt++;
            z80_busack = !((ack_cnt >= ack_dly) && !(drop_ack && active));
        end else begin
            ack_cnt = 0;
            z80_busack = 1'b1;
        end
    end

    // Strobe length: T2 + T3 plus one T-state per wait state. WAIT passes through
    // two sync flops, so a decision at edge E0+d sees the raw level from edge E0+d-2.
    function automatic int exp_len(input logic io, input int w);
        int n = 0;
        for (int j = 0; j < 64; j++) begin
            if ((j == 0 && io) || (T_DIV * (j + 1) - 2 < w)) n++;
            else break;
        end
        return T_DIV * (2 + n);
    endfunction

    // Issues one command (caller is at a negedge) and waits for its response.
    task automatic run_cmd(input logic wr, input logic io, input logic [15:0] a,
                           input logic [7:0] wd, input logic [7:0] din, input int w,
                           output logic ok, output logic [7:0] rd, output int len,
                           output logic extra);
        int t;
        wait_len  = w;
        z80_d_in  = din;
        cmd_write = wr;
        cmd_io    = io;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = rsp_valid;
        #1;
        rd  = rsp_rdata;
        len = last_len;
        @(negedge clk);
        extra = rsp_valid;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({z80_busreq, z80_mreq, z80_iorq, z80_rd, z80_wr, z80_ctrl_oe, z80_d_oe,
             cmd_ready, rsp_valid} !== 9'b111110000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want %b", {z80_busreq, z80_mreq, z80_iorq,
                     z80_rd, z80_wr, z80_ctrl_oe, z80_d_oe, cmd_ready, rsp_valid}, 9'b111110000);
        end
        n_cmp++;
        if ({z80_a, z80_d_out, rsp_rdata} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", {z80_a, z80_d_out, rsp_rdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_mem_read();
        logic ok, extra;
        logic [7:0] rd;
        int len;
        ack_dly = 3;
        run_cmd(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 0, ok, rd, len, extra);
        n_cmp++;
        if (!ok || rd !== 8'hA5) begin
            n_err++;
            $display("FAIL memrd_data: got ok=%b %h want ok=1 a5", ok, rd);
        end
        n_cmp++;
        if (len !== 2 * T_DIV) begin
            n_err++;
            $display("FAIL memrd_len: got %0d want %0d", len, 2 * T_DIV);
        end
        n_cmp++;
        if ({obs_io, obs_wr, obs_rd, addr_stable, doe_any} !== 5'b00110 || obs_addr !== 16'h1234) begin
            n_err++;
            $display("FAIL memrd_bus: got io/wr/rd/stable/doe=%b a=%h want 00110 1234",
                     {obs_io, obs_wr, obs_rd, addr_stable, doe_any}, obs_addr);
        end
        n_cmp++;
        if (extra !== 1'b0) begin
            n_err++;
            $display("FAIL memrd_pulse: got rsp_valid %b a clk later want 0", extra);
        end
    endtask

    task automatic test_io_write();
        logic ok, extra;
        logic [7:0] rd;
        int len, rc;
        rc = rsp_cnt;
        doe_cnt = 0;
        run_cmd(1'b1, 1'b1, 16'h3039, 8'h5A, 8'h00, 0, ok, rd, len, extra);
        n_cmp++;
        if (!ok || len !== 3 * T_DIV) begin
            n_err++;
            $display("FAIL iowr_len: got ok=%b len=%0d want 1 %0d", ok, len, 3 * T_DIV);
        end
        n_cmp++;
        if ({obs_io, obs_wr, obs_rd, doe_all} !== 4'b1101 || obs_dout !== 8'h5A || obs_addr !== 16'h3039) begin
            n_err++;
            $display("FAIL iowr_bus: got io/wr/rd/doe=%b d=%h a=%h want 1101 5a 3039",
                     {obs_io, obs_wr, obs_rd, doe_all}, obs_dout, obs_addr);
        end
        n_cmp++;
        if (doe_cnt !== 4 * T_DIV) begin
            n_err++;
            $display("FAIL iowr_doe_clks: got %0d want %0d", doe_cnt, 4 * T_DIV);
        end
        n_cmp++;
        if (rsp_cnt - rc !== 1 || rd !== 8'hA5) begin
            n_err++;
            $display("FAIL iowr_rsp: got pulses=%0d rdata=%h want 1 a5", rsp_cnt - rc, rd);
        end
    endtask

    task automatic test_wait();
        logic ok, extra;
        logic [7:0] rd;
        int len;
        run_cmd(1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h3C, 10, ok, rd, len, extra);
        n_cmp++;
        if (!ok || len !== 4 * T_DIV || rd !== 8'h3C) begin
            n_err++;
            $display("FAIL wait10_len: got ok=%b len=%0d rd=%h want 1 %0d 3c", ok, len, rd, 4 * T_DIV);
        end
    endtask

    task automatic test_back_to_back();
        logic ok1, ok2, extra;
        logic [7:0] rd;
        int len1, len2, f0;
        repeat (20) @(negedge clk);
        f0 = busreq_falls;
        run_cmd(1'b0, 1'b0, 16'h0100, 8'h00, 8'h11, 0, ok1, rd, len1, extra);
        @(negedge clk);
        run_cmd(1'b1, 1'b0, 16'h0101, 8'h77, 8'h00, 0, ok2, rd, len2, extra);
        n_cmp++;
        if (!ok1 || !ok2 || len2 !== 2 * T_DIV || rd !== 8'h11) begin
            n_err++;
            $display("FAIL b2b_cycles: got ok=%b%b len=%0d rd=%h want 11 %0d 11", ok1, ok2, len2, rd, 2 * T_DIV);
        end
        n_cmp++;
        if (busreq_falls - f0 !== 1) begin
            n_err++;
            $display("FAIL b2b_busreq: got %0d busreq assertions want 1", busreq_falls - f0);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (rise_cyc - rsp_cyc !== HOLD || ready_at_rise !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: got %0d clks ready=%b want %0d 0", rise_cyc - rsp_cyc, ready_at_rise, HOLD);
        end
        n_cmp++;
        if ({z80_busreq, z80_ctrl_oe, cmd_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL released_idle: got %b want 101", {z80_busreq, z80_ctrl_oe, cmd_ready});
        end
    endtask

    task automatic test_ack_drop();
        logic ok, extra;
        logic [7:0] rd;
        int len;
        drop_ack = 1'b1;
        run_cmd(1'b0, 1'b0, 16'h4242, 8'h00, 8'hC3, 0, ok, rd, len, extra);
        drop_ack = 1'b0;
        n_cmp++;
        if (!ok || len !== 2 * T_DIV || rd !== 8'hC3) begin
            n_err++;
            $display("FAIL ack_drop: got ok=%b len=%0d rd=%h want 1 %0d c3", ok, len, rd, 2 * T_DIV);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int t, rc;
        repeat (20) @(negedge clk);
        wait_len  = 0;
        cmd_write = 1'b0;
        cmd_io    = 1'b0;
        cmd_addr  = 16'h5555;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (run < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (run < 2) begin
            n_err++;
            $display("FAIL midrst_reach_t2: got run=%0d want >=2", run);
        end
        rc = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({z80_mreq, z80_iorq, z80_rd, z80_wr, z80_ctrl_oe, z80_busreq, z80_d_oe} !== 7'b1111010) begin
            n_err++;
            $display("FAIL midrst_async: got %b want 1111010",
                     {z80_mreq, z80_iorq, z80_rd, z80_wr, z80_ctrl_oe, z80_busreq, z80_d_oe});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (rsp_cnt !== rc || {cmd_ready, z80_busreq} !== 2'b11 || rsp_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_after: got rsp=%0d ready/busreq=%b rd=%h want %0d 11 00",
                     rsp_cnt - rc, {cmd_ready, z80_busreq}, rsp_rdata, 0);
        end
    endtask

    task automatic test_random();
        logic ok, extra, wr, io, in_own;
        logic [7:0] rd, wd, din, last_rd;
        logic [15:0] a;
        int len, w, g, f0;
        last_rd = 8'h00;
        in_own  = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            wr  = 1'($urandom);
            io  = 1'($urandom);
            a   = 16'($urandom);
            wd  = 8'($urandom);
            din = 8'($urandom);
            w   = $urandom_range(0, 14);
            g   = $urandom_range(0, 10);
            ack_dly = $urandom_range(1, 6);
            f0 = busreq_falls;
            run_cmd(wr, io, a, wd, din, w, ok, rd, len, extra);
            if (!wr) last_rd = din;
            n_cmp++;
            if (!ok || len !== exp_len(io, w) || rd !== last_rd || extra !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d_rsp: got ok=%b len=%0d rd=%h extra=%b want 1 %0d %h 0",
                         i, ok, len, rd, extra, exp_len(io, w), last_rd);
            end
            n_cmp++;
            if ({obs_io, obs_wr, obs_rd} !== {io, wr, !wr} || obs_addr !== a || !addr_stable
                || (wr && (obs_dout !== wd || !doe_all)) || (!wr && doe_any)) begin
                n_err++;
                $display("FAIL rand%0d_bus: got io/wr/rd=%b a=%h d=%h doe=%b%b want %b %h %h",
                         i, {obs_io, obs_wr, obs_rd}, obs_addr, obs_dout, doe_all, doe_any,
                         {io, wr, !wr}, a, wd);
            end
            n_cmp++;
            if (busreq_falls - f0 !== (in_own ? 0 : 1)) begin
                n_err++;
                $display("FAIL rand%0d_busreq: got %0d assertions want %0d", i, busreq_falls - f0, in_own ? 0 : 1);
            end
            // Command lands 1+g clks after rsp_valid; OWN accepts up to HOLD-1 clks after it.
            in_own = (1 + g) <= HOLD - 1;
            repeat (g) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait();
        test_back_to_back();
        test_ack_drop();
        test_reset_mid_cycle();
        test_random();
        n_cmp++;
        if (viol !== 0) begin
            n_err++;
            $display("FAIL strobe_exclusive: got %0d violations want 0", viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
